// File: rtl/avmm_pio_master.sv
// rtl/avmm_pio_master.sv - Avalon-MM initiator issuing single writes, reads and bounded poll loops to a PIO slave
module avmm_pio_master #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_POLLS    = 16,
    parameter int POLL_GAP     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [DATA_W-1:0] cmd_mask,
    input  logic [DATA_W-1:0] cmd_match,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [7:0]        rsp_polls,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic              read,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
);
    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;
    localparam logic [2:0] WAIT_LAST  = 3'(READ_LATENCY - 1);
    localparam logic [3:0] GAP_LAST   = (POLL_GAP > 0) ? 4'(POLL_GAP - 1) : 4'd0;
    localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLLS);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_RESP} state_t;

    state_t            state, state_nx;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] mask_q, match_q;
    logic [7:0]        poll_cnt;
    logic [2:0]        wait_cnt;
    logic [3:0]        gap_cnt;
    logic              wait_last, hit, done;

    assign wait_last = (wait_cnt == WAIT_LAST);
    assign hit       = ((readdata & mask_q) == (match_q & mask_q));
    // A plain read always finishes on its single sample; a poll finishes on a hit or when the budget is spent.
    assign done      = (op_q == OP_RD) || hit || (poll_cnt == POLL_LIMIT);
    assign rsp_polls = poll_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Strobes and handshakes decode from the state register so an async reset drops them at once.
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid) begin
                    state_nx = (cmd_op == OP_RSV) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                write    = (op_q == OP_WR);
                read     = (op_q != OP_WR);
                state_nx = (op_q == OP_WR) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (wait_last) begin
                    if (done) begin
                        state_nx = S_RESP;
                    end else if (POLL_GAP == 0) begin
                        state_nx = S_ISSUE;
                    end else begin
                        state_nx = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = S_ISSUE;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= OP_WR;
            mask_q    <= '0;
            match_q   <= '0;
            address   <= '0;
            writedata <= '0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            poll_cnt  <= '0;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        mask_q    <= cmd_mask;
                        match_q   <= cmd_match;
                        rsp_rdata <= '0;
                        rsp_error <= (cmd_op == OP_RSV);
                        poll_cnt  <= '0;
                        if (cmd_op != OP_RSV) begin
                            address <= cmd_addr;
                        end
                        if (cmd_op == OP_WR) begin
                            writedata <= cmd_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    if (op_q != OP_WR) begin
                        poll_cnt <= poll_cnt + 8'd1;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    gap_cnt  <= '0;
                    if (wait_last) begin
                        rsp_rdata <= readdata;
                        if (done) begin
                            rsp_error <= (op_q == OP_POLL) && !hit;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        poll_cnt <= '0;
                    end
                end
                default: begin
                    poll_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avmm_pio_master.sv
// tb/tb_avmm_pio_master.sv - randomized self-checking bench for avmm_pio_master with a cycle-level reference model
module tb_avmm_pio_master;
    localparam int AW   = 3;
    localparam int DW   = 32;
    localparam int RL   = 1;
    localparam int MAXP = 4;
    localparam int GAP  = 2;
    localparam int STEP = 1 + RL + GAP;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [DW-1:0] cmd_mask = '0;
    logic [DW-1:0] cmd_match = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [7:0]    rsp_polls;
    logic [AW-1:0] address;
    logic          write;
    logic          read;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata = '0;

    always #5 clk = ~clk;

    avmm_pio_master #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .MAX_POLLS(MAXP), .POLL_GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .cmd_match(cmd_match),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_polls(rsp_polls),
        .address(address), .write(write), .read(read), .writedata(writedata), .readdata(readdata)
    );

    logic [DW-1:0] slave_seq [16];
    int            seq_base = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            pin_en = 1'b0;
    logic [DW-1:0] pin_rdata = '0;
    bit            pin_err = 1'b0;
    int            pin_polls = 0, pin_writes = 0, pin_reads = 0, pin_gap = -1, pin_lat = -1;

    // Slave: the n-th read of a command returns slave_seq[n] only in cycle strobe+RL, junk otherwise.
    int            scyc = 0;
    int            rd_total = 0;
    int            sidx, sslot;
    logic [DW-1:0] due_dat [8];
    bit            due_vld [8];

    always @(negedge clk) begin
        scyc++;
        sslot = scyc % 8;
        due_vld[sslot[2:0]] = 1'b0;
        if (reset) begin
            for (int i = 0; i < 8; i++) due_vld[i] = 1'b0;
        end else if (read) begin
            sidx  = rd_total - seq_base;
            sslot = (scyc + RL) % 8;
            due_vld[sslot[2:0]] = 1'b1;
            due_dat[sslot[2:0]] = (sidx >= 0 && sidx < 16) ? slave_seq[sidx[3:0]] : $urandom;
            rd_total++;
        end
    end

    int rslot;
    always @(posedge clk) begin
        #1;
        rslot = (scyc + 1) % 8;
        if (due_vld[rslot[2:0]]) readdata = due_dat[rslot[2:0]];
        else                     readdata = $urandom;
    end

    // Reference model: per command, when each strobe must occur and what the response must hold.
    int            cyc = 0;
    bit            in_cmd = 1'b0;
    int            acc_cyc = 0, w_cyc = -1, r_first = 0, r_n = 0, rsp_cyc = 0;
    logic [DW-1:0] e_rdata = '0;
    bit            e_err = 1'b0;
    int            e_polls = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_wdata = '0;
    int            obs_w = 0, obs_r = 0, obs_gap = -1, last_strobe = -1, first_rsp = -1;
    bit            ew, er, ev;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit read_due(input int c);
        return (r_n > 0) && (c >= r_first) && (((c - r_first) % STEP) == 0) && (((c - r_first) / STEP) < r_n);
    endfunction

    task automatic model_accept();
        logic [DW-1:0] v;
        int n;
        bit h;
        acc_cyc = cyc; w_cyc = -1; r_n = 0; r_first = cyc + 1;
        e_rdata = '0; e_err = 1'b0; e_polls = 0;
        obs_w = 0; obs_r = 0; obs_gap = -1; last_strobe = -1; first_rsp = -1;
        case (cmd_op)
            2'b00: begin
                w_cyc = cyc + 1; rsp_cyc = cyc + 2;
                last_addr = cmd_addr; last_wdata = cmd_wdata;
            end
            2'b01: begin
                r_n = 1; rsp_cyc = cyc + 2 + RL;
                e_rdata = slave_seq[0]; e_polls = 1; last_addr = cmd_addr;
            end
            2'b10: begin
                h = 1'b0; n = 0; v = '0;
                while (!h && n < MAXP) begin
                    v = slave_seq[n[3:0]];
                    n++;
                    h = ((v & cmd_mask) == (cmd_match & cmd_mask));
                end
                r_n = n; rsp_cyc = cyc + 1 + (n - 1) * STEP + RL + 1;
                e_rdata = v; e_err = !h; e_polls = n; last_addr = cmd_addr;
            end
            default: begin
                rsp_cyc = cyc + 1; e_err = 1'b1;
            end
        endcase
        in_cmd = 1'b1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_write", 32'(write), 32'd0);
            chk("rst_read", 32'(read), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("rst_address", 32'(address), 32'd0);
            chk("rst_writedata", writedata, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_error", 32'(rsp_error), 32'd0);
            chk("rst_rsp_polls", 32'(rsp_polls), 32'd0);
            in_cmd = 1'b0; last_addr = '0; last_wdata = '0;
        end else begin
            ew = in_cmd && (cyc == w_cyc);
            er = in_cmd && read_due(cyc);
            ev = in_cmd && (cyc >= rsp_cyc);
            chk("write", 32'(write), 32'(ew));
            chk("read", 32'(read), 32'(er));
            chk("address", 32'(address), 32'(last_addr));
            chk("writedata", writedata, last_wdata);
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            chk("cmd_ready", 32'(cmd_ready), 32'(!in_cmd));
            if (ev) begin
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_error", 32'(rsp_error), 32'(e_err));
                chk("rsp_polls", 32'(rsp_polls), 32'(e_polls));
            end
            if (in_cmd) begin
                if (write) begin obs_w++; last_strobe = cyc; end
                if (read) begin
                    if (obs_r > 0) obs_gap = cyc - last_strobe;
                    obs_r++; last_strobe = cyc;
                end
                if (rsp_valid && first_rsp < 0) first_rsp = cyc;
            end
            if (in_cmd && rsp_valid && rsp_ready) begin
                if (pin_en) begin
                    chk("pin_rdata", rsp_rdata, pin_rdata);
                    chk("pin_error", 32'(rsp_error), 32'(pin_err));
                    chk("pin_polls", 32'(rsp_polls), 32'(pin_polls));
                    chk("pin_writes", 32'(obs_w), 32'(pin_writes));
                    chk("pin_reads", 32'(obs_r), 32'(pin_reads));
                    if (pin_gap >= 0) chk("pin_read_spacing", 32'(obs_gap), 32'(pin_gap));
                    if (pin_lat >= 0) chk("pin_strobe_to_rsp", 32'(first_rsp - last_strobe), 32'(pin_lat));
                end
                in_cmd = 1'b0;
            end else if (!in_cmd && cmd_valid && cmd_ready) begin
                model_accept();
            end else if (in_cmd && (cyc - acc_cyc) > 400) begin
                n_tests++; n_fail++;
                $display("FAIL rsp_timeout: no response %0d cycles after accept at cycle %0d", cyc - acc_cyc, acc_cyc);
                in_cmd = 1'b0;
            end
        end
    end

    task automatic set_pins(input logic [DW-1:0] rd, input bit er_, input int pl, input int pw,
                            input int pr, input int pg, input int lt);
        pin_en = 1'b1; pin_rdata = rd; pin_err = er_; pin_polls = pl;
        pin_writes = pw; pin_reads = pr; pin_gap = pg; pin_lat = lt;
    endtask

    task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] mk, input logic [DW-1:0] mt);
        @(posedge clk); #1;
        seq_base = rd_total;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk; cmd_match = mt;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_wdata = $urandom;
    endtask

    task automatic recv(input int hold, input bit rnd, input bit junk);
        for (int i = 0; i < 300; i++) begin
            rsp_ready = (i >= hold) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            cmd_valid = junk ? ($urandom_range(0, 1) == 1) : 1'b0;
            cmd_op = 2'($urandom); cmd_addr = AW'($urandom);
            @(negedge clk);
            if (rsp_valid && rsp_ready) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0; pin_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) slave_seq[i] = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        set_pins(32'd0, 1'b0, 0, 1, 0, -1, 1);
        send(2'b00, 3'd0, 32'd1, 32'd0, 32'd0);
        recv(0, 1'b0, 1'b0);

        slave_seq[0] = 32'h0000_00A5;
        set_pins(32'h0000_00A5, 1'b0, 1, 0, 1, -1, 2);
        send(2'b01, 3'd1, 32'd0, 32'd0, 32'd0);
        recv(1, 1'b0, 1'b0);

        slave_seq[0] = 32'd1; slave_seq[1] = 32'd1; slave_seq[2] = 32'd0;
        set_pins(32'd0, 1'b0, 3, 0, 3, 4, 2);
        send(2'b10, 3'd1, 32'd0, 32'd1, 32'd0);
        recv(0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) slave_seq[i] = 32'd1;
        set_pins(32'd1, 1'b1, 4, 0, 4, 4, 2);
        send(2'b10, 3'd1, 32'd0, 32'd1, 32'd0);
        recv(2, 1'b0, 1'b0);

        set_pins(32'd0, 1'b1, 0, 0, 0, -1, -1);
        send(2'b11, 3'd1, 32'd0, 32'd0, 32'd0);
        recv(6, 1'b0, 1'b1);

        send(2'b10, 3'd1, 32'd0, 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        set_pins(32'd0, 1'b0, 0, 1, 0, -1, 1);
        send(2'b00, 3'd1, 32'h1234_5678, 32'd0, 32'd0);
        recv(0, 1'b1, 1'b0);

        slave_seq[0] = 32'hDEAD_BEEF;
        send(2'b01, 3'd0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < 16; i++) slave_seq[i] = $urandom & 32'hF;
            send(($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)), AW'($urandom),
                 $urandom, $urandom & 32'hF, $urandom & 32'hF);
            recv($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/avmm_pio_master.md
Name: avmm_pio_master

Overview:
- Avalon-MM initiator that drives register accesses into PIO-style slaves (direction register at address 0, data register at address 1).
- Accepts single commands from a local controller over a valid/ready port and issues one write, one read, or a bounded poll loop on the bus.
- Returns one response per command over a valid/ready port.
- The target slave has no waitrequest and a fixed read latency, so all bus timing is set by the parameters below.

Parameters:
- ADDR_W, 3, width of the bus address.
- DATA_W, 32, width of the bus and command data.
- READ_LATENCY, 1, cycles from the read-strobe cycle to valid readdata; legal range 1..7.
- MAX_POLLS, 16, maximum number of reads in one poll command; legal range 1..255.
- POLL_GAP, 2, idle cycles between consecutive poll reads; legal range 0..15.

Ports:
- clk  in  1  clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 reserved.
- cmd_addr  in  ADDR_W  target register address.
- cmd_wdata  in  DATA_W  write data (op 00 only).
- cmd_mask  in  DATA_W  poll compare mask (op 10 only).
- cmd_match  in  DATA_W  poll compare value (op 10 only).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATA_W  read data (last sample for poll; 0 for write and reserved).
- rsp_error  out  1  1 = poll timeout or reserved op.
- rsp_polls  out  8  number of bus reads performed by the command.
- address  out  ADDR_W  bus address.
- write  out  1  bus write strobe.
- read  out  1  bus read strobe.
- writedata  out  DATA_W  bus write data.
- readdata  in  DATA_W  bus read data.

Behaviour:
- Reset state: address=0, write=0, read=0, writedata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_polls=0, FSM=IDLE, all counters 0.
- cmd_ready = (state==IDLE) && !reset; it is combinational from state.
- Reset asserted mid-command abandons the command immediately: strobes drop asynchronously and no response is ever produced.
- States: IDLE, ISSUE, WAIT, GAP, RESP.
- IDLE:
  - On cmd_valid&&cmd_ready, latch op, addr, wdata, mask and match.
  - Ops 00/01/10 go to ISSUE.
  - Op 11 goes to RESP with rsp_error=1, rsp_polls=0, and no bus activity.
- ISSUE (exactly one cycle):
  - address=latched addr.
  - Op 00: write=1, writedata=wdata, next state RESP.
  - Op 01/10: read=1, increment poll count, next state WAIT.
  - write and read are never high in the same cycle.
  - address and writedata are registered and hold their values after the strobe.
- WAIT:
  - Read strobe in cycle N; readdata is sampled at the clock edge ending cycle N+READ_LATENCY.
  - Op 01 then goes to RESP with rsp_rdata=sample.
  - Op 10: if (sample & mask)==(match & mask), go to RESP, error 0.
  - Op 10: else if poll count==MAX_POLLS, go to RESP, error 1, rsp_rdata=last sample.
  - Op 10: else go to GAP, or straight to ISSUE when POLL_GAP=0.
- GAP: wait POLL_GAP cycles with no strobes, then go to ISSUE.
- RESP:
  - rsp_valid=1; rsp_* stay stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE: rsp_valid=0, poll count=0.
  - rsp_ready already high when rsp_valid rises completes the response in that same cycle.
- Throughput:
  - Write: minimum 3 cycles from accept to the next accept (accept, ISSUE, RESP).
  - Read: minimum 3+READ_LATENCY cycles from accept to the next accept.
- Only one command is in flight at a time; cmd_valid outside IDLE is ignored (cmd_ready=0).
- rsp_polls saturates at MAX_POLLS; a poll whose first read matches reports 1.

Test Plan:
- Write op 00, addr 0, wdata 1 → exactly one cycle with write=1, address=0, writedata=1, read=0. rsp_valid the following cycle with error 0, polls 0, rdata 0.
- Read op 01, addr 1, slave model returns 0x000000A5 at READ_LATENCY=1 → one read pulse; rsp_rdata=0xA5, error 0, polls 1, rsp_valid 2 cycles after the strobe.
- Poll op 10, mask 1, match 0, slave returns 1,1,0, POLL_GAP=2 → read pulses spaced 4 cycles apart (READ_LATENCY+1+POLL_GAP); response error 0, polls 3, rdata 0.
- Poll timeout, MAX_POLLS=4, slave always returns 1, mask 1, match 0 → exactly 4 reads, then error 1, polls 4, rdata 1.
- Reserved op 11 → no write or read pulse; response error 1, polls 0. Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp data stay stable and cmd_ready stays 0 until the handshake.
- Reset pulse during the GAP of a poll → strobes 0 and rsp_valid 0 immediately. cmd_ready=1 in the first cycle after release; a following write completes normally.
